// File: rtl/matrix_multiply_nxn_mac.sv
// Sequential NxN matrix multiplier: one MAC per cycle, C = A x B published atomically on completion.
// Optional macro MATMUL_SIGNED_EN selects two's-complement operands and results (unsigned when undefined).
module matrix_multiply_nxn_mac #(
    parameter int N  = 3,
    parameter int DW = 8,
    localparam int CW = 2*DW+2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [N*N*DW-1:0]   A,
    input  logic [N*N*DW-1:0]   B,
    output logic [N*N*CW-1:0]   C,
    output logic                busy,
    output logic                done
);
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N-1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state, state_nxt;
    logic   accept, issue, finish, last_idx;

    logic [DW-1:0] opa [N][N];
    logic [DW-1:0] opb [N][N];

    logic [IW-1:0] ci, cj, ck;

    logic [CW-1:0] ae, be, prod_nxt;
    logic [CW-1:0] prod;
    logic [IW-1:0] pi, pj, pk;
    logic          p_vld;

    logic [CW-1:0] acc, acc_nxt;
    logic [CW-1:0] rbuf [N][N];
    logic [N*N*CW-1:0] res;

    assign last_idx = (ci == LAST) && (cj == LAST) && (ck == LAST);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)    state_nxt = RUN;
            RUN:     if (last_idx) state_nxt = DRAIN;
            DRAIN:                 state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != IDLE);
        accept = (state == IDLE) && start;
        issue  = (state == RUN);
        finish = (state == DRAIN);
    end

    // ---------------- operand capture ----------------
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    opa[r][c] <= A[DW*(r*N+c) +: DW];
                    opb[r][c] <= B[DW*(r*N+c) +: DW];
                end
        end
    end

    // ---------------- index walk: k fastest, then j, then i ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ci <= '0;
            cj <= '0;
            ck <= '0;
        end else if (accept) begin
            ci <= '0;
            cj <= '0;
            ck <= '0;
        end else if (issue) begin
            if (ck == LAST) begin
                ck <= '0;
                if (cj == LAST) begin
                    cj <= '0;
                    ci <= ci + 1'b1;
                end else begin
                    cj <= cj + 1'b1;
                end
            end else begin
                ck <= ck + 1'b1;
            end
        end
    end

    // ---------------- multiply stage ----------------
    always_comb begin
`ifdef MATMUL_SIGNED_EN
        ae = {{(CW-DW){opa[ci][ck][DW-1]}}, opa[ci][ck]};
        be = {{(CW-DW){opb[ck][cj][DW-1]}}, opb[ck][cj]};
`else
        ae = {{(CW-DW){1'b0}}, opa[ci][ck]};
        be = {{(CW-DW){1'b0}}, opb[ck][cj]};
`endif
        // CW-bit modular product is exact for both encodings since the true result fits in CW bits
        prod_nxt = ae * be;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod  <= '0;
            pi    <= '0;
            pj    <= '0;
            pk    <= '0;
            p_vld <= 1'b0;
        end else begin
            p_vld <= issue;
            if (issue) begin
                prod <= prod_nxt;
                pi   <= ci;
                pj   <= cj;
                pk   <= ck;
            end
        end
    end

    // ---------------- accumulate stage ----------------
    assign acc_nxt = (pk == '0) ? prod : acc + prod;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      acc <= '0;
        else if (p_vld) acc <= acc_nxt;
    end

    always_ff @(posedge clk) begin
        if (p_vld && pk == LAST) rbuf[pi][pj] <= acc_nxt;
    end

    // The last dot product lands on the same edge C is published, so forward it.
    always_comb begin
        res = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                if (p_vld && pk == LAST && pi == IW'(r) && pj == IW'(c))
                    res[CW*(r*N+c) +: CW] = acc_nxt;
                else
                    res[CW*(r*N+c) +: CW] = rbuf[r][c];
            end
    end

    // ---------------- result publish ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            C    <= '0;
            done <= 1'b0;
        end else begin
            done <= finish;
            if (finish) C <= res;
        end
    end

endmodule
